// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch program counter with boot hold-off, stall, misaligned trap
//            and retired-fetch counter. Optional return-address stack under
//            the PC_RAS_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter int              ALIGN        = 2,
    parameter int              BOOT_DELAY   = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_target,
    input  logic            call_en,
    input  logic            ret_en,
    input  logic            trap_clear,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic            valid,
    output logic            misalign_trap,
    output logic [XLEN-1:0] trap_pc,
    output logic [31:0]     retire_count
);

    localparam logic [XLEN-1:0] c_INC        = XLEN'(1) << ALIGN;
    localparam logic [XLEN-1:0] c_ALIGN_MASK = c_INC - XLEN'(1);
    localparam int              c_BOOT_W     = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [XLEN-1:0]       r_pc_q, w_pc_d;
    logic [XLEN-1:0]       r_trap_pc_q, w_trap_pc_d;
    logic [31:0]           r_retire_q, w_retire_d;
    logic [c_BOOT_W-1:0]   r_boot_cnt_q, w_boot_cnt_d;

    logic [XLEN-1:0]       w_jump_tgt;
    logic [XLEN-1:0]       w_target;
    logic                  w_redirect;
    logic                  w_misaligned;

`ifdef PC_RAS_EN
    localparam int c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]    r_ras_q [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_sp_q, w_sp_d, w_sp_pop, w_top_idx;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d, w_cnt_pop;
    logic               w_ras_hit, w_do_op, w_push;

    // r_sp_q points at the next free slot; the newest entry sits just below it
    assign w_top_idx  = (r_sp_q == '0) ? c_PTR_W'(RAS_DEPTH - 1) : r_sp_q - c_PTR_W'(1);
    assign w_ras_hit  = ret_en && (r_cnt_q != '0);
    assign w_jump_tgt = w_ras_hit ? r_ras_q[w_top_idx] : jump_target;
    assign w_do_op    = (r_state_q == S_RUN) && !stall && jump_en;
    assign w_push     = w_do_op && call_en;

    always_comb begin
        w_sp_pop  = r_sp_q;
        w_cnt_pop = r_cnt_q;
        if (w_do_op && w_ras_hit) begin
            w_sp_pop  = w_top_idx;
            w_cnt_pop = r_cnt_q - c_CNT_W'(1);
        end
        w_sp_d  = w_sp_pop;
        w_cnt_d = w_cnt_pop;
        if (w_push) begin
            w_sp_d = (w_sp_pop == c_PTR_W'(RAS_DEPTH - 1)) ? '0 : w_sp_pop + c_PTR_W'(1);
            if (w_cnt_pop != c_CNT_W'(RAS_DEPTH)) begin
                w_cnt_d = w_cnt_pop + c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp_q  <= '0;
            r_cnt_q <= '0;
        end else begin
            r_sp_q  <= w_sp_d;
            r_cnt_q <= w_cnt_d;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by r_cnt_q
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras_q[w_sp_pop] <= r_pc_q + c_INC;
        end
    end
`else
    logic w_unused_ras;
    assign w_unused_ras = call_en | ret_en;
    assign w_jump_tgt   = jump_target;
`endif

    assign w_redirect   = jump_en | branch_taken;
    assign w_target     = jump_en ? w_jump_tgt : branch_target;
    assign w_misaligned = (w_target & c_ALIGN_MASK) != '0;

    always_comb begin
        w_state_d    = r_state_q;
        w_pc_d       = r_pc_q;
        w_trap_pc_d  = r_trap_pc_q;
        w_retire_d   = r_retire_q;
        w_boot_cnt_d = r_boot_cnt_q;
        case (r_state_q)
            S_BOOT: begin
                w_boot_cnt_d = r_boot_cnt_q + c_BOOT_W'(1);
                if (BOOT_DELAY == 0 || r_boot_cnt_q == c_BOOT_W'(BOOT_DELAY - 1)) begin
                    w_state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (w_redirect && w_misaligned) begin
                        w_pc_d      = TRAP_VECTOR;
                        w_trap_pc_d = w_target;
                        w_state_d   = S_TRAP;
                    end else begin
                        w_pc_d     = w_redirect ? w_target : r_pc_q + c_INC;
                        w_retire_d = r_retire_q + 32'd1;
                    end
                end
            end
            S_TRAP: begin
                if (trap_clear) begin
                    w_state_d = S_RUN;
                end
            end
            default: w_state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q    <= S_BOOT;
            r_pc_q       <= RESET_VECTOR;
            r_trap_pc_q  <= '0;
            r_retire_q   <= '0;
            r_boot_cnt_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_pc_q       <= w_pc_d;
            r_trap_pc_q  <= w_trap_pc_d;
            r_retire_q   <= w_retire_d;
            r_boot_cnt_q <= w_boot_cnt_d;
        end
    end

    assign pc_out        = r_pc_q;
    assign pc_next       = w_pc_d;
    assign valid         = (r_state_q == S_RUN);
    assign misalign_trap = (r_state_q == S_TRAP);
    assign trap_pc       = r_trap_pc_q;
    assign retire_count  = r_retire_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed scoreboard bench for pc_sequencer (PC_RAS_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, branch_taken = 1'b0, jump_en = 1'b0;
    logic        call_en = 1'b0, ret_en = 1'b0, trap_clear = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0;
    logic [31:0] pc_out, pc_next, trap_pc, retire_count;
    logic        valid, misalign_trap;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .call_en       (call_en),
        .ret_en        (ret_en),
        .trap_clear    (trap_clear),
        .pc_out        (pc_out),
        .pc_next       (pc_next),
        .valid         (valid),
        .misalign_trap (misalign_trap),
        .trap_pc       (trap_pc),
        .retire_count  (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        tr;
        logic [31:0] tpc;
        logic [31:0] rc;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                         input logic je, input logic [31:0] jt,
                         input logic ce, input logic re, input logic tc);
        stall = st; branch_taken = br; branch_target = bt;
        jump_en = je; jump_target = jt; call_en = ce; ret_en = re; trap_clear = tc;
    endtask

    // Queue the state expected after the coming edge, then advance one cycle
    task automatic step(input logic v, input logic [31:0] pc, input logic tr,
                        input logic [31:0] tpc, input logic [31:0] rc, input string nm);
        exp_t e;
        e.v = v; e.pc = pc; e.tr = tr; e.tpc = tpc; e.rc = rc; e.nm = nm;
        sb.push_back(e);
        if (!reset) begin
            #1;
            checks++;
            if (pc_next !== pc) begin
                errors++;
                $display("FAIL pc_next_%s got=%h want=%h", nm, pc_next, pc);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (valid !== e.v || pc_out !== e.pc || misalign_trap !== e.tr ||
                    trap_pc !== e.tpc || retire_count !== e.rc) begin
                    errors++;
                    $display("FAIL %s got pc=%h v=%b trap=%b tpc=%h ret=%0d want pc=%h v=%b trap=%b tpc=%h ret=%0d",
                             e.nm, pc_out, valid, misalign_trap, trap_pc, retire_count,
                             e.pc, e.v, e.tr, e.tpc, e.rc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, "rst_a");
        step(0, 32'h0, 0, 0, 0, "rst_b");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0, 0, "boot");
        step(1, 32'h0, 0, 0, 0, "boot_exit");
        step(1, 32'h4, 0, 0, 1, "seq4");
        step(1, 32'h8, 0, 0, 2, "seq8");
        step(1, 32'hC, 0, 0, 3, "seqC");
        step(1, 32'h10, 0, 0, 4, "seq10");

        drive(1, 1, 32'h40, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 32'h10, 0, 0, 4, "stall");
        drive(0, 1, 32'h40, 0, 0, 0, 0, 0);
        step(1, 32'h40, 0, 0, 5, "branch");
        drive(0, 1, 32'h40, 1, 32'h80, 0, 0, 0);
        step(1, 32'h80, 0, 0, 6, "jump_prio");

        drive(0, 1, 32'h42, 0, 0, 0, 0, 0);
        step(0, 32'h100, 1, 32'h42, 6, "misalign");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 32'h100, 1, 32'h42, 6, "trap_hold");
        drive(1, 1, 32'h40, 0, 0, 0, 0, 0);
        step(0, 32'h100, 1, 32'h42, 6, "trap_ign_br");
        drive(0, 0, 0, 1, 32'h80, 0, 0, 0);
        step(0, 32'h100, 1, 32'h42, 6, "trap_ign_j");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 32'h100, 1, 32'h42, 6, "trap_hold");
        step(0, 32'h100, 1, 32'h42, 6, "trap_hold");
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 32'h100, 0, 32'h42, 6, "trap_clr");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h104, 0, 32'h42, 7, "post_trap");
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 32'h108, 0, 32'h42, 8, "clr_in_run");

        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        step(1, 32'hFFFF_FFFC, 0, 32'h42, 9, "jump_top");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h0, 0, 32'h42, 10, "wrap");
        step(1, 32'h4, 0, 32'h42, 11, "after_wrap");

        #2 reset = 1'b1;
        #1;
        checks++;
        if (pc_out !== 32'h0 || valid !== 1'b0 || retire_count !== 32'h0 || trap_pc !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got pc=%h v=%b ret=%0d tpc=%h want pc=0 v=0 ret=0 tpc=0",
                     pc_out, valid, retire_count, trap_pc);
        end
        step(0, 32'h0, 0, 0, 0, "rst_hold");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0, 0, "reboot");
        step(1, 32'h0, 0, 0, 0, "reboot_exit");

        drive(0, 0, 0, 1, 32'h6, 0, 0, 0);
        step(0, 32'h100, 1, 32'h6, 0, "misalign_j");
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 32'h100, 0, 32'h6, 0, "clr2");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h104, 0, 32'h6, 1, "seq104");

`ifdef PC_RAS_EN
        drive(0, 0, 0, 1, 32'h20, 0, 0, 0);
        step(1, 32'h20, 0, 32'h6, 2, "to20");
        drive(0, 0, 0, 1, 32'h200, 1, 0, 0);
        step(1, 32'h200, 0, 32'h6, 3, "call200");
        drive(0, 0, 0, 1, 32'h0, 0, 1, 0);
        step(1, 32'h24, 0, 32'h6, 4, "ret24");
        drive(0, 0, 0, 1, 32'h300, 1, 0, 0);
        step(1, 32'h300, 0, 32'h6, 5, "call300");
        drive(0, 0, 0, 1, 32'h400, 1, 0, 0);
        step(1, 32'h400, 0, 32'h6, 6, "call400");
        drive(0, 0, 0, 1, 32'h500, 1, 0, 0);
        step(1, 32'h500, 0, 32'h6, 7, "call500");
        drive(0, 0, 0, 1, 32'h600, 1, 0, 0);
        step(1, 32'h600, 0, 32'h6, 8, "call600");
        drive(0, 0, 0, 1, 32'h700, 1, 0, 0);
        step(1, 32'h700, 0, 32'h6, 9, "call700");
        drive(0, 0, 0, 1, 32'h40, 0, 1, 0);
        step(1, 32'h604, 0, 32'h6, 10, "ret1");
        step(1, 32'h504, 0, 32'h6, 11, "ret2");
        step(1, 32'h404, 0, 32'h6, 12, "ret3");
        step(1, 32'h304, 0, 32'h6, 13, "ret4");
        step(1, 32'h40, 0, 32'h6, 14, "ret_empty");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
`endif

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter block; successor to the plain registered program_counter.
- Owns the next-PC decision internally (sequential increment, branch, jump) instead of taking a precomputed pc_in.
- Adds a boot hold-off, stall, misaligned-target trap with clear handshake, and a retired-fetch counter.
- Sits at the head of the single-cycle RISC-V fetch path; drives the instruction-memory address.

Parameters:
XLEN, 32, PC width in bits.
RESET_VECTOR, 32'h0000_0000, PC after reset; must be aligned.
TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect; must be aligned.
ALIGN, 2, log2 of instruction size in bytes; increment is 1<<ALIGN.
BOOT_DELAY, 4, cycles held in BOOT after reset before fetching; 0 allowed.
RAS_DEPTH, 4, return-address-stack entries; used only with PC_RAS_EN.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
stall  input  1  hold PC this cycle
branch_taken  input  1  redirect to branch_target
branch_target  input  XLEN  branch destination
jump_en  input  1  redirect to jump_target
jump_target  input  XLEN  jump destination
call_en  input  1  jump is a call (PC_RAS_EN only)
ret_en  input  1  jump is a return (PC_RAS_EN only)
trap_clear  input  1  acknowledge trap, resume fetch
pc_out  output  XLEN  current fetch address (registered)
pc_next  output  XLEN  value pc_out takes at next edge (combinational)
valid  output  1  pc_out is a real fetch
misalign_trap  output  1  trap pending (level)
trap_pc  output  XLEN  offending redirect target
retire_count  output  32  count of non-stalled RUN cycles

Behaviour:
- Reset (async, immediate, also mid-operation): pc_out=RESET_VECTOR, state=BOOT, boot counter=0, valid=0, misalign_trap=0, trap_pc=0, retire_count=0, RAS emptied.
- BOOT: pc_out held, valid=0. Counter increments each cycle. Move to RUN on the edge where the counter equals BOOT_DELAY-1. With BOOT_DELAY=0, move to RUN on the first edge after reset deasserts. All other inputs are ignored.
- RUN: valid=1.
  - Target priority: jump_en > branch_taken > pc_out + (1<<ALIGN).
  - Addition wraps modulo 2^XLEN.
- Stall in RUN: stall=1 holds pc_out and retire_count. It also discards any redirect presented that cycle; upstream must keep the redirect asserted until stall drops.
- Retired-fetch count: retire_count increments on every non-stalled RUN edge and wraps at 2^32.
- Misaligned redirect: a redirect whose target has nonzero low ALIGN bits is not loaded. Instead, on that edge:
  - pc_out=TRAP_VECTOR, trap_pc=target, misalign_trap=1, state=TRAP.
  - retire_count is not incremented.
- TRAP: valid=0, pc_out held at TRAP_VECTOR, redirects and stall ignored.
  - trap_clear=1 moves to RUN on that edge. misalign_trap clears, pc_out stays TRAP_VECTOR, and the first fetch is TRAP_VECTOR.
  - trap_pc holds its value until the next trap or reset.
- trap_clear outside TRAP has no effect.
- pc_next always equals the value pc_out will take at the next edge, given current inputs.

Optional Feature:
PC_RAS_EN:
- Defined: a RAS_DEPTH-entry return-address stack.
  - jump_en&call_en (not stalled) pushes pc_out+(1<<ALIGN).
  - jump_en&ret_en pops, and the popped value replaces jump_target.
  - ret_en on an empty stack falls back to jump_target.
  - Push when full overwrites the oldest entry (circular).
  - call_en&ret_en together: pop then push (target = popped value).
  - Misaligned popped value traps like any other redirect; the pop still takes effect.
- Not defined: call_en and ret_en are ignored and no stack storage exists.

Test Plan:
1. Reset high 20ns, release, BOOT_DELAY=4 -> valid=0 and pc_out=0x0 for 4 cycles, then pc_out 0x0,0x4,0x8,0xC with valid=1; retire_count=4 after four RUN edges.
2. In RUN at pc 0x10, assert stall 3 cycles with branch_taken=1, target 0x40 -> pc_out stays 0x10 and retire_count frozen. Keep branch after stall drops -> pc_out=0x40 next edge.
3. jump_en=1 target 0x80 and branch_taken=1 target 0x40 in the same cycle -> pc_out=0x80.
4. branch_taken target 0x42 -> pc_out=0x100, misalign_trap=1, trap_pc=0x42, valid=0. Hold 5 cycles, then pulse trap_clear -> pc_out 0x100, 0x104 with valid=1.
5. pc_out=0xFFFF_FFFC, no redirect -> pc_out wraps to 0x0. Assert reset asynchronously mid-cycle -> pc_out=0x0 and valid=0 before the next edge.
6. (PC_RAS_EN) Call at pc 0x20 to 0x200, then ret_en with jump_target 0x0 -> pc_out=0x24. Five calls with RAS_DEPTH=4, then five returns -> the first four returns pop the four newest return addresses; the fifth falls back to jump_target.
